// File: rtl/rasterizer_mem_arbiter_pkg.sv
// Shared types and constants for the rasterizer SDRAM arbiter.
package rasterizer_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

   typedef logic port_id_t;

   localparam port_id_t PORT_FETCH = 1'b0;
   localparam port_id_t PORT_WB    = 1'b1;

   // With two ports the round-robin successor is simply the other port.
   function automatic port_id_t other_port(input port_id_t p);
      return ~p;
   endfunction

endpackage

// File: rtl/rasterizer_mem_arbiter_tag_fifo.sv
// In-order tag FIFO: remembers which port issued each outstanding read.
module arb_tag_fifo
   import rasterizer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     push,
   input  logic     pop,
   input  port_id_t din,
   output logic     full,
   output logic     empty,
   output port_id_t head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   port_id_t      mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Tag storage carries no control meaning when empty, so it is not reset.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/rasterizer_mem_arbiter.sv
// Round-robin arbiter sharing the SDRAM master between depth fetch (p0) and write-back (p1).
module rasterizer_mem_arbiter
   import rasterizer_pkg::*;
#(
   parameter int ADDR_W          = 26,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] p0_address,
   input  logic              p0_read,
   input  logic              p0_write,
   input  logic [31:0]       p0_writedata,
   input  logic [3:0]        p0_byteenable,
   output logic              p0_waitrequest,
   output logic [31:0]       p0_readdata,
   output logic              p0_readdatavalid,
   input  logic [ADDR_W-1:0] p1_address,
   input  logic              p1_read,
   input  logic              p1_write,
   input  logic [31:0]       p1_writedata,
   input  logic [3:0]        p1_byteenable,
   output logic              p1_waitrequest,
   output logic [31:0]       p1_readdata,
   output logic              p1_readdatavalid,
   output logic [ADDR_W-1:0] master_address,
   output logic              master_read,
   output logic              master_write,
   output logic [31:0]       master_writedata,
   output logic [3:0]        master_byteenable,
   input  logic [31:0]       master_readdata,
   input  logic              master_readdatavalid,
   input  logic              master_waitrequest,
   output logic              err_orphan
);

   arb_state_t state, state_nxt;
   port_id_t   grant, grant_nxt;
   port_id_t   rr_ptr, rr_nxt;
   logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
   port_id_t   fifo_head;
   logic       elig0, elig1;

   logic [ADDR_W-1:0] sel_address;
   logic              sel_read, sel_write;
   logic [31:0]       sel_writedata;
   logic [3:0]        sel_byteenable;

   // A read is only eligible while there is a tag slot for its return.
   assign elig0 = p0_write || (p0_read && !fifo_full);
   assign elig1 = p1_write || (p1_read && !fifo_full);

   assign sel_address    = (grant == PORT_WB) ? p1_address    : p0_address;
   assign sel_read       = (grant == PORT_WB) ? p1_read       : p0_read;
   assign sel_write      = (grant == PORT_WB) ? p1_write      : p0_write;
   assign sel_writedata  = (grant == PORT_WB) ? p1_writedata  : p0_writedata;
   assign sel_byteenable = (grant == PORT_WB) ? p1_byteenable : p0_byteenable;

   // Returns are steered by the oldest tag; data fans out to both ports untouched.
   assign fifo_pop         = master_readdatavalid && !fifo_empty;
   assign p0_readdatavalid = fifo_pop && (fifo_head == PORT_FETCH);
   assign p1_readdatavalid = fifo_pop && (fifo_head == PORT_WB);
   assign p0_readdata      = master_readdata;
   assign p1_readdata      = master_readdata;

   // Next-state, grant decision and master/port muxing.
   always_comb begin
      state_nxt         = state;
      grant_nxt         = grant;
      rr_nxt            = rr_ptr;
      fifo_push         = 1'b0;
      master_address    = '0;
      master_read       = 1'b0;
      master_write      = 1'b0;
      master_writedata  = '0;
      master_byteenable = 4'b1111;
      p0_waitrequest    = 1'b1;
      p1_waitrequest    = 1'b1;
      case (state)
         ARB_IDLE: begin
            if (elig0 && elig1) begin
               grant_nxt = rr_ptr;
               state_nxt = ARB_HOLD;
            end else if (elig0) begin
               grant_nxt = PORT_FETCH;
               state_nxt = ARB_HOLD;
            end else if (elig1) begin
               grant_nxt = PORT_WB;
               state_nxt = ARB_HOLD;
            end
         end
         ARB_HOLD: begin
            master_address    = sel_address;
            master_read       = sel_read;
            master_write      = sel_write;
            master_writedata  = sel_writedata;
            master_byteenable = sel_byteenable;
            if (grant == PORT_WB) p1_waitrequest = master_waitrequest;
            else                  p0_waitrequest = master_waitrequest;
            if (!(sel_read || sel_write)) begin
               // Requester withdrew its command: abandon the grant quietly.
               state_nxt = ARB_IDLE;
            end else if (!master_waitrequest) begin
               fifo_push = sel_read;
               rr_nxt    = other_port(grant);
               state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Control registers; the orphan flag is sticky until reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= ARB_IDLE;
         grant      <= PORT_FETCH;
         rr_ptr     <= PORT_FETCH;
         err_orphan <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         rr_ptr     <= rr_nxt;
         err_orphan <= err_orphan || (master_readdatavalid && fifo_empty);
      end
   end

   arb_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (grant),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Directed self-checking bench for rasterizer_mem_arbiter.
module tb_rasterizer_mem_arbiter;

   logic        clock;
   logic        reset;
   logic [25:0] p0_address, p1_address;
   logic        p0_read, p0_write, p1_read, p1_write;
   logic [31:0] p0_writedata, p1_writedata;
   logic [3:0]  p0_byteenable, p1_byteenable;
   logic        p0_waitrequest, p1_waitrequest;
   logic [31:0] p0_readdata, p1_readdata;
   logic        p0_readdatavalid, p1_readdatavalid;
   logic [25:0] master_address;
   logic        master_read, master_write;
   logic [31:0] master_writedata;
   logic [3:0]  master_byteenable;
   logic [31:0] master_readdata;
   logic        master_readdatavalid, master_waitrequest;
   logic        err_orphan;

   int vectors = 0;
   int errors  = 0;

   rasterizer_mem_arbiter #(
      .ADDR_W          (26),
      .MAX_OUTSTANDING (8)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .p0_address           (p0_address),
      .p0_read              (p0_read),
      .p0_write             (p0_write),
      .p0_writedata         (p0_writedata),
      .p0_byteenable        (p0_byteenable),
      .p0_waitrequest       (p0_waitrequest),
      .p0_readdata          (p0_readdata),
      .p0_readdatavalid     (p0_readdatavalid),
      .p1_address           (p1_address),
      .p1_read              (p1_read),
      .p1_write             (p1_write),
      .p1_writedata         (p1_writedata),
      .p1_byteenable        (p1_byteenable),
      .p1_waitrequest       (p1_waitrequest),
      .p1_readdata          (p1_readdata),
      .p1_readdatavalid     (p1_readdatavalid),
      .master_address       (master_address),
      .master_read          (master_read),
      .master_write         (master_write),
      .master_writedata     (master_writedata),
      .master_byteenable    (master_byteenable),
      .master_readdata      (master_readdata),
      .master_readdatavalid (master_readdatavalid),
      .master_waitrequest   (master_waitrequest),
      .err_orphan           (err_orphan)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      p0_address = '0; p0_read = 0; p0_write = 0; p0_writedata = '0; p0_byteenable = 4'hf;
      p1_address = '0; p1_read = 0; p1_write = 0; p1_writedata = '0; p1_byteenable = 4'hf;
      master_readdata = '0; master_readdatavalid = 0; master_waitrequest = 0;
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b0;
      clear_inputs();
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Drives one command that the idle master accepts immediately, then releases it.
   task automatic issue(input bit port, input bit wr, input logic [25:0] a, input logic [31:0] d);
      tick();
      if (port == 1'b0) begin
         p0_address = a; p0_read = !wr; p0_write = wr; p0_writedata = d;
      end else begin
         p1_address = a; p1_read = !wr; p1_write = wr; p1_writedata = d;
      end
      tick();
      tick();
      if (port == 1'b0) begin p0_read = 0; p0_write = 0; end
      else begin p1_read = 0; p1_write = 0; end
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      p0_read = 1; p0_address = 26'h11;
      p1_read = 1; p1_address = 26'h22;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) reset = 1'b1;
         #1;
         vectors++; if (p0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_p0_wait got=%b exp=1", p0_waitrequest); end
         vectors++; if (p1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_p1_wait got=%b exp=1", p1_waitrequest); end
         vectors++; if ({master_read, master_write} !== 2'b00) begin errors++; $display("FAIL reset_master_cmd got=%b exp=00", {master_read, master_write}); end
         vectors++; if (master_address !== 26'h0) begin errors++; $display("FAIL reset_master_addr got=%h exp=0", master_address); end
         vectors++; if (master_byteenable !== 4'hf) begin errors++; $display("FAIL reset_master_be got=%h exp=f", master_byteenable); end
         vectors++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL reset_rdv got=%b exp=00", {p0_readdatavalid, p1_readdatavalid}); end
         vectors++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_orphan); end
      end
      tick();
      p1_read = 0;
      #1;
      vectors++; if (master_read !== 1'b1 || master_address !== 26'h11) begin errors++; $display("FAIL first_grant got rd=%b addr=%h exp rd=1 addr=11", master_read, master_address); end
      vectors++; if ({p0_waitrequest, p1_waitrequest} !== 2'b01) begin errors++; $display("FAIL first_grant_wait got=%b exp=01", {p0_waitrequest, p1_waitrequest}); end
      tick();
      p0_read = 0;
   endtask

   task automatic test_contention();
      logic [25:0] exp_addr;
      logic        hold;
      logic        port;
      do_reset();
      tick();
      p0_read = 1; p0_address = 26'h100;
      p1_write = 1; p1_address = 26'h200; p1_writedata = 32'hDEADBEEF;
      #1;
      vectors++; if ({p0_waitrequest, p1_waitrequest} !== 2'b11) begin errors++; $display("FAIL cont_idle_wait got=%b exp=11", {p0_waitrequest, p1_waitrequest}); end
      tick(); #1;
      vectors++; if (master_read !== 1'b1 || master_write !== 1'b0 || master_address !== 26'h100) begin errors++; $display("FAIL cont_p0_read got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=100", master_read, master_write, master_address); end
      vectors++; if ({p0_waitrequest, p1_waitrequest} !== 2'b01) begin errors++; $display("FAIL cont_p0_wait got=%b exp=01", {p0_waitrequest, p1_waitrequest}); end
      tick();
      p0_read = 0;
      #1;
      vectors++; if ({master_read, master_write, p1_waitrequest} !== 3'b001) begin errors++; $display("FAIL cont_gap got=%b exp=001", {master_read, master_write, p1_waitrequest}); end
      tick(); #1;
      vectors++; if (master_write !== 1'b1 || master_address !== 26'h200 || master_writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL cont_p1_write got wr=%b addr=%h data=%h exp wr=1 addr=200 data=deadbeef", master_write, master_address, master_writedata); end
      vectors++; if ({p0_waitrequest, p1_waitrequest} !== 2'b10) begin errors++; $display("FAIL cont_p1_wait got=%b exp=10", {p0_waitrequest, p1_waitrequest}); end
      tick();
      p1_write = 0;
      // Both ports now request writes continuously: grants must alternate p0, p1, p0.
      tick();
      p0_write = 1; p0_address = 26'hA0;
      p1_write = 1; p1_address = 26'hB0;
      for (int i = 0; i < 6; i++) begin
         tick(); #1;
         hold = (i % 2 == 0);
         port = ((i / 2) % 2 == 1);
         exp_addr = port ? 26'hB0 : 26'hA0;
         if (hold) begin
            vectors++; if (master_write !== 1'b1 || master_address !== exp_addr) begin errors++; $display("FAIL rr_grant_%0d got wr=%b addr=%h exp wr=1 addr=%h", i, master_write, master_address, exp_addr); end
            vectors++; if ({p0_waitrequest, p1_waitrequest} !== {port, !port}) begin errors++; $display("FAIL rr_wait_%0d got=%b exp=%b", i, {p0_waitrequest, p1_waitrequest}, {port, !port}); end
         end else begin
            vectors++; if ({master_write, p0_waitrequest, p1_waitrequest} !== 3'b011) begin errors++; $display("FAIL rr_idle_%0d got=%b exp=011", i, {master_write, p0_waitrequest, p1_waitrequest}); end
         end
      end
      p0_write = 0; p1_write = 0;
   endtask

   task automatic test_wait_hold();
      do_reset();
      tick();
      p1_write = 1; p1_address = 26'h3C0; p1_writedata = 32'hCAFEF00D; p1_byteenable = 4'b0011;
      master_waitrequest = 1;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 0) begin p0_read = 1; p0_address = 26'h40; end
         if (k == 5) master_waitrequest = 0;
         #1;
         vectors++; if (master_write !== 1'b1 || master_address !== 26'h3C0 || master_writedata !== 32'hCAFEF00D || master_byteenable !== 4'b0011) begin errors++; $display("FAIL hold_stable_%0d got wr=%b addr=%h data=%h be=%b", k, master_write, master_address, master_writedata, master_byteenable); end
         vectors++; if ({p0_waitrequest, p1_waitrequest} !== {1'b1, (k != 5)}) begin errors++; $display("FAIL hold_wait_%0d got=%b exp=%b", k, {p0_waitrequest, p1_waitrequest}, {1'b1, (k != 5)}); end
      end
      tick();
      p1_write = 0;
      #1;
      vectors++; if ({master_write, master_read, p0_waitrequest} !== 3'b001) begin errors++; $display("FAIL hold_after_accept got=%b exp=001", {master_write, master_read, p0_waitrequest}); end
      tick(); #1;
      vectors++; if (master_read !== 1'b1 || master_address !== 26'h40 || p0_waitrequest !== 1'b0) begin errors++; $display("FAIL hold_p0_grant got rd=%b addr=%h wait=%b exp rd=1 addr=40 wait=0", master_read, master_address, p0_waitrequest); end
      tick();
      p0_read = 0;
   endtask

   task automatic test_routing();
      logic [31:0] d;
      logic        port;
      do_reset();
      issue(1'b0, 1'b0, 26'h10, 32'h0);
      issue(1'b1, 1'b0, 26'h20, 32'h0);
      issue(1'b0, 1'b0, 26'h30, 32'h0);
      for (int i = 0; i < 3; i++) begin
         d = 32'hA + 32'(i);
         port = (i == 1);
         tick();
         master_readdatavalid = 1; master_readdata = d;
         #1;
         vectors++; if ({p0_readdatavalid, p1_readdatavalid} !== {!port, port}) begin errors++; $display("FAIL route_rdv_%0d got=%b exp=%b", i, {p0_readdatavalid, p1_readdatavalid}, {!port, port}); end
         vectors++; if (p0_readdata !== d || p1_readdata !== d) begin errors++; $display("FAIL route_data_%0d got p0=%h p1=%h exp=%h", i, p0_readdata, p1_readdata, d); end
      end
      tick();
      master_readdatavalid = 0;
      #1;
      vectors++; if ({p0_readdatavalid, p1_readdatavalid, err_orphan} !== 3'b000) begin errors++; $display("FAIL route_after got=%b exp=000", {p0_readdatavalid, p1_readdatavalid, err_orphan}); end
   endtask

   task automatic test_full_fifo();
      do_reset();
      for (int i = 0; i < 8; i++) issue(1'b0, 1'b0, 26'(i * 4), 32'h0);
      tick();
      p0_read = 1; p0_address = 26'h99;
      p1_write = 1; p1_address = 26'h77; p1_writedata = 32'h12345678;
      #1;
      vectors++; if (p0_waitrequest !== 1'b1) begin errors++; $display("FAIL full_p0_idle got=%b exp=1", p0_waitrequest); end
      tick(); #1;
      vectors++; if (master_write !== 1'b1 || master_read !== 1'b0 || master_address !== 26'h77 || {p0_waitrequest, p1_waitrequest} !== 2'b10) begin errors++; $display("FAIL full_write_through got wr=%b rd=%b addr=%h wait=%b", master_write, master_read, master_address, {p0_waitrequest, p1_waitrequest}); end
      tick();
      p1_write = 0;
      #1;
      vectors++; if ({master_read, master_write} !== 2'b00) begin errors++; $display("FAIL full_gap got=%b exp=00", {master_read, master_write}); end
      tick();
      master_readdatavalid = 1; master_readdata = 32'h1;
      #1;
      vectors++; if (master_read !== 1'b0 || p0_waitrequest !== 1'b1) begin errors++; $display("FAIL full_stall got rd=%b wait=%b exp rd=0 wait=1", master_read, p0_waitrequest); end
      vectors++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b10) begin errors++; $display("FAIL full_return got=%b exp=10", {p0_readdatavalid, p1_readdatavalid}); end
      tick();
      master_readdatavalid = 0;
      #1;
      vectors++; if (master_read !== 1'b0) begin errors++; $display("FAIL full_decision got rd=%b exp=0", master_read); end
      tick(); #1;
      vectors++; if (master_read !== 1'b1 || master_address !== 26'h99 || p0_waitrequest !== 1'b0) begin errors++; $display("FAIL full_ninth_grant got rd=%b addr=%h wait=%b exp rd=1 addr=99 wait=0", master_read, master_address, p0_waitrequest); end
      tick();
      p0_read = 0;
   endtask

   task automatic test_drop();
      do_reset();
      tick();
      p0_read = 1; p0_address = 26'h60; master_waitrequest = 1;
      tick(); #1;
      vectors++; if (master_read !== 1'b1 || p0_waitrequest !== 1'b1) begin errors++; $display("FAIL drop_stalled got rd=%b wait=%b exp rd=1 wait=1", master_read, p0_waitrequest); end
      tick();
      p0_read = 0; master_waitrequest = 0;
      #1;
      vectors++; if (master_read !== 1'b0 || master_address !== 26'h60) begin errors++; $display("FAIL drop_mirror got rd=%b addr=%h exp rd=0 addr=60", master_read, master_address); end
      tick();
      p0_write = 1; p0_address = 26'h61;
      p1_write = 1; p1_address = 26'h62;
      #1;
      vectors++; if ({p0_waitrequest, p1_waitrequest} !== 2'b11) begin errors++; $display("FAIL drop_idle got=%b exp=11", {p0_waitrequest, p1_waitrequest}); end
      tick(); #1;
      vectors++; if (master_address !== 26'h61 || {p0_waitrequest, p1_waitrequest} !== 2'b01) begin errors++; $display("FAIL drop_rr_kept got addr=%h wait=%b exp addr=61 wait=01", master_address, {p0_waitrequest, p1_waitrequest}); end
      tick();
      p0_write = 0; p1_write = 0;
      tick();
      master_readdatavalid = 1;
      #1;
      vectors++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL drop_no_push got=%b exp=00", {p0_readdatavalid, p1_readdatavalid}); end
      tick();
      master_readdatavalid = 0;
      #1;
      vectors++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL drop_orphan got=%b exp=1", err_orphan); end
   endtask

   task automatic test_orphan();
      do_reset();
      tick();
      master_readdatavalid = 1; master_readdata = 32'h5;
      #1;
      vectors++; if ({p0_readdatavalid, p1_readdatavalid, err_orphan} !== 3'b000) begin errors++; $display("FAIL orphan_strobe got=%b exp=000", {p0_readdatavalid, p1_readdatavalid, err_orphan}); end
      tick();
      master_readdatavalid = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky_%0d got=%b exp=1", i, err_orphan); end
         tick();
      end
      do_reset();
      #1;
      vectors++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_cleared got=%b exp=0", err_orphan); end
      // A read issued before reset returns afterwards and must be treated as an orphan.
      issue(1'b0, 1'b0, 26'h50, 32'h0);
      do_reset();
      tick();
      master_readdatavalid = 1;
      #1;
      vectors++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL inflight_strobe got=%b exp=00", {p0_readdatavalid, p1_readdatavalid}); end
      tick();
      master_readdatavalid = 0;
      #1;
      vectors++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL inflight_orphan got=%b exp=1", err_orphan); end
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      test_reset();
      test_contention();
      test_wait_hold();
      test_routing();
      test_full_fifo();
      test_drop();
      test_orphan();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/rasterizer_mem_arbiter.md
# rasterizer_mem_arbiter

Two-port arbiter that shares the single 32-bit SDRAM bus master of the rasterizer between the depth-fetch stage (port 0) and the pixel write-back stage (port 1). Both ports are slave-side Avalon-MM views with waitrequest and pipelined reads. The arbiter grants one command at a time, round-robin, holds the grant until the SDRAM accepts the command, and tracks outstanding reads in order so that each `readdatavalid` returns to the port that issued it.

## Interface
- `ADDR_W`, 26: address width, all ports.
- `MAX_OUTSTANDING`, 8: reads in flight; power of two, ≥ 2.
- `clock` in 1: single clock domain.
- `reset` in 1: synchronous, active-low.
- `p0_address`, `p1_address` in ADDR_W: requester address.
- `p0_read`, `p1_read`, `p0_write`, `p1_write` in 1: requester command. read and write are never both high on one port.
- `p0_writedata`, `p1_writedata` in 32: write data.
- `p0_byteenable`, `p1_byteenable` in 4: byte enables.
- `p0_waitrequest`, `p1_waitrequest` out 1: command not accepted this cycle.
- `p0_readdata`, `p1_readdata` out 32: returned data.
- `p0_readdatavalid`, `p1_readdatavalid` out 1: return strobe.
- `master_address` out ADDR_W.
- `master_read`, `master_write` out 1.
- `master_writedata` out 32.
- `master_byteenable` out 4.
- `master_readdata` in 32.
- `master_readdatavalid`, `master_waitrequest` in 1.
- `err_orphan` out 1: sticky. Set by a readdatavalid that arrives with no tracked read.

## Operation
- States: `ARB_IDLE`, `ARB_HOLD`. Registers: `grant` (port id), `rr_ptr` (preferred port), tag FIFO, `err_orphan`.
- Eligible request: `pX_write`, or `pX_read` while the tag FIFO is not full.
- In `ARB_IDLE`:
  - One eligible port: register `grant` = that port and go to `ARB_HOLD`.
  - Both eligible: grant `rr_ptr`.
  - None eligible: stay in `ARB_IDLE`.
- In `ARB_HOLD`:
  - Master outputs mirror the granted port combinationally: address, read, write, writedata, byteenable.
  - Granted `pX_waitrequest` = `master_waitrequest`.
  - Accept = `!master_waitrequest`. On accept: if the command is a read, push the grant id into the tag FIFO; set `rr_ptr` = the other port; go to `ARB_IDLE`.
  - If the granted port drops its command before accept, that is a protocol violation. Go to `ARB_IDLE` with no push and no `rr_ptr` change.
- The ungranted port, and both ports in `ARB_IDLE`, see waitrequest = 1.
- Master outputs in `ARB_IDLE`: read = write = 0, address/writedata = 0, byteenable = 4'b1111.
- Read return:
  - On `master_readdatavalid`: pop the FIFO head tag and assert `pT_readdatavalid` for that port only, same cycle (combinational).
  - Both `pX_readdata` = `master_readdata` unconditionally.
  - Push and pop in the same cycle are allowed. Occupancy is unchanged; a pop on a full FIFO frees the slot next cycle.
- Orphan return (`master_readdatavalid` with the FIFO empty):
  - Neither port's readdatavalid asserts.
  - `err_orphan` <= 1 and stays set until reset.
- Reset (synchronous, mid-transaction included):
  - State `ARB_IDLE`, `rr_ptr` = 0, FIFO empty, `err_orphan` = 0.
  - Returns still in flight from before reset become orphans.

## Timing
- Reset values of outputs: master_read/write 0, master_address 0, master_writedata 0, master_byteenable 4'b1111, both waitrequest 1, both readdatavalid 0, err_orphan 0.
- Arbitration latency: request seen in `ARB_IDLE` at cycle N → command on master at N+1. Accept at N+1 at the earliest.
- Throughput: at most one command per 2 cycles (IDLE/HOLD alternation).
- Return latency through the arbiter: 0 cycles. Returns arrive in issue order (SDRAM controller guarantee).
- FIFO full at the decision cycle blocks new read grants only; writes stay eligible.

## Structure
- `rasterizer_pkg`: `arb_state_t` enum {ARB_IDLE, ARB_HOLD}, `port_id_t` (1 bit), constants `PORT_FETCH = 0`, `PORT_WB = 1`.
- Sub-module `arb_tag_fifo`:
  - Depth MAX_OUTSTANDING, 1-bit entries.
  - Wrapping pointers plus a count.
  - Outputs `full`, `empty`, `head`.
  - Synchronous active-low reset.
- Top level holds the FSM, round-robin pointer, output muxes and the error flag.

## Test plan
- Reset: hold reset low 3 cycles while both ports request → waitrequests 1, master_read/write 0, err_orphan 0. First grant is to p0 on the cycle after release.
- Contention: p0 read 0x100 and p1 write 0x200 (data 0xDEADBEEF) in the same cycle, master_waitrequest 0 → p0 read appears at N+1, p1 write at N+3 with writedata 0xDEADBEEF. `rr_ptr` alternates.
- Wait-hold: master_waitrequest held high 5 cycles during a p1 write → master outputs stable, p0 stays stalled, accept on cycle 6 → p0 granted two cycles later.
- Routing: p0 reads 0x10, p1 reads 0x20, p0 reads 0x30; returns 0xA, 0xB, 0xC → readdatavalid sequence p0, p1, p0 with the matching data.
- Full FIFO: issue 8 p0 reads with no returns → a 9th p0 read stalls while a p1 write still goes through. One return → the 9th read is granted.
- Orphan: with no reads outstanding, pulse master_readdatavalid → no port strobe, err_orphan = 1 until reset.
